// File: rtl/pwm_dac.sv
// pwm_dac: one-bit PWM output stage fed by a valid/ready sample stream.
// Each accepted sample sets the duty cycle of one 2^WIDTH-clock PWM period.
// A single holding register decouples the upstream handshake from the
// period boundary, so the generator is paced at one sample per period.
// When no sample is waiting at a boundary, the previous duty is repeated
// and a saturating underrun counter records the miss.

module pwm_dac #(
  parameter int WIDTH      = 10,
  parameter int UNDERRUN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  pwm,
  output logic                  frame,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  // Last counter value of a period; the edge leaving it is the boundary.
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Midscale duty so the filtered output rests at half range after reset.
  localparam logic [WIDTH-1:0] DUTY_MID = {1'b1, {(WIDTH-1){1'b0}}};

  // Ceiling of the underrun counter; it sticks here instead of wrapping.
  localparam logic [UNDERRUN_W-1:0] UNDERRUN_MAX = '1;

  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      duty_q, duty_d;
  logic [WIDTH-1:0]      hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  pwm_q, pwm_d;
  logic                  frame_q, frame_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;

  logic                  xfer;
  logic                  boundary;

  // Ready only reflects the holding register, and is forced low during reset
  // so nothing is accepted on an edge that is about to clear the state.
  assign s_ready  = !hold_full_q && !rst;
  assign xfer     = s_valid && s_ready;
  assign boundary = (cnt_q == CNT_MAX);

  // Next-state logic: period counter, holding register, duty reload,
  // underrun accounting and the registered compare outputs.
  always_comb begin
    cnt_d       = cnt_q + WIDTH'(1);
    duty_d      = duty_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;

    // The boundary decision uses the pre-edge hold_full, so a sample that
    // arrives on the boundary edge itself waits for the next boundary and
    // the current one still counts as an underrun.
    if (boundary) begin
      if (hold_full_q) begin
        duty_d      = hold_q;
        hold_full_d = 1'b0;
      end else if (underrun_q != UNDERRUN_MAX) begin
        underrun_d  = underrun_q + UNDERRUN_W'(1);
      end
    end

    // A transfer can only happen while the register is empty, so it never
    // collides with the boundary clearing a full register.
    if (xfer) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    // Strict less-than: duty 0 is constant low and full scale leaves one
    // low cycle, so 100% duty is never produced.
    pwm_d   = (cnt_q < duty_q);
    frame_d = (cnt_q == '0);
  end

  // State register with synchronous reset; reset also drops a held sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      duty_q      <= DUTY_MID;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      pwm_q       <= 1'b0;
      frame_q     <= 1'b0;
      underrun_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      pwm_q       <= pwm_d;
      frame_q     <= frame_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pwm          = pwm_q;
  assign frame        = frame_q;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: scoreboard bench for pwm_dac.
// Every accepted sample is pushed with the period it must appear in; the
// monitor measures each PWM period and pops the matching entry. A second,
// narrow instance with permanently idle input exercises counter saturation.

module tb_pwm_dac;

  localparam int W            = 10;
  localparam int UW           = 8;
  localparam int PERIOD       = 1 << W;
  localparam int SW           = 4;
  localparam int SMALL_PERIOD = 1 << SW;
  localparam int UNDER_SAT    = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  sData = '0;
  logic          sValid = 1'b0;
  logic          sReady;
  logic          pwm;
  logic          frame;
  logic [UW-1:0] underrunCnt;

  logic [SW-1:0] smallData = '0;
  logic          smallValid = 1'b0;
  logic          smallReady;
  logic          smallPwm;
  logic          smallFrame;
  logic [UW-1:0] smallUnderrun;

  typedef struct {
    int value;
    int target;
  } entry_t;

  entry_t sb[$];

  int compareCount  = 0;
  int mismatchCount = 0;
  int cyc           = 0;
  int xferCount     = 0;
  bit started       = 1'b0;
  bit rstSeen       = 1'b0;
  bit expHoldFull   = 1'b0;

  int lastDuty  = PERIOD / 2;
  int expUnder  = 0;
  int highCnt   = 0;
  int firstLow  = PERIOD;
  bit measuring = 1'b0;

  pwm_dac #(.WIDTH(W), .UNDERRUN_W(UW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (sData),
    .s_valid      (sValid),
    .s_ready      (sReady),
    .pwm          (pwm),
    .frame        (frame),
    .underrun_cnt (underrunCnt)
  );

  pwm_dac #(.WIDTH(SW), .UNDERRUN_W(UW)) dutSmall (
    .clk          (clk),
    .rst          (rst),
    .s_data       (smallData),
    .s_valid      (smallValid),
    .s_ready      (smallReady),
    .pwm          (smallPwm),
    .frame        (smallFrame),
    .underrun_cnt (smallUnderrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, observed, expected);
    end
  endtask

  // Handshake model: cycle count since reset release, holding-register
  // occupancy, and the period each accepted sample is due to appear in.
  always @(posedge clk) begin : trackModel
    int     phase;
    bit     xfer;
    entry_t e;
    started = 1'b1;
    if (rst) begin
      rstSeen     = 1'b1;
      cyc         = 0;
      expHoldFull = 1'b0;
      sb.delete();
    end else begin
      rstSeen = 1'b0;
      phase   = cyc % PERIOD;
      xfer    = sValid && !expHoldFull;
      if (phase == PERIOD - 1) expHoldFull = 1'b0;
      if (xfer) begin
        expHoldFull = 1'b1;
        e.value     = int'(sData);
        e.target    = cyc / PERIOD + ((phase == PERIOD - 1) ? 2 : 1);
        sb.push_back(e);
        xferCount++;
      end
      cyc++;
    end
  end

  // Output monitor, sampled mid-cycle: ready, frame, underrun count and the
  // measured shape of each PWM period against the scoreboard.
  always @(negedge clk) begin : monitorOutputs
    int pos;
    int period;
    if (started) begin
      checkOutput("s_ready", int'(sReady), int'(!rst && !expHoldFull));
      if (rstSeen) begin
        checkOutput("reset_pwm", int'(pwm), 0);
        checkOutput("reset_frame", int'(frame), 0);
        checkOutput("reset_underrun", int'(underrunCnt), 0);
        lastDuty  = PERIOD / 2;
        expUnder  = 0;
        measuring = 1'b0;
      end else begin
        pos    = (cyc - 1) % PERIOD;
        period = (cyc - 1) / PERIOD;
        checkOutput("frame", int'(frame), int'(pos == 0));
        if (pos == 0) begin
          if (period > 0 && !(sb.size() > 0 && sb[0].target == period)) begin
            if (expUnder < UNDER_SAT) expUnder++;
          end
          checkOutput("underrun_cnt", int'(underrunCnt), expUnder);
          measuring = 1'b1;
          highCnt   = 0;
          firstLow  = PERIOD;
        end
        if (measuring) begin
          if (pwm) highCnt++;
          else if (firstLow == PERIOD) firstLow = pos;
          if (pos == PERIOD - 1) begin
            if (sb.size() > 0 && sb[0].target == period) begin
              lastDuty = sb[0].value;
              void'(sb.pop_front());
            end
            checkOutput("duty_high_cycles", highCnt, lastDuty);
            checkOutput("duty_first_low", firstLow, lastDuty);
            measuring = 1'b0;
          end
        end
      end
      if (cyc % SMALL_PERIOD == 0) begin
        checkOutput("small_underrun", int'(smallUnderrun),
                    (cyc / SMALL_PERIOD < UNDER_SAT) ? cyc / SMALL_PERIOD : UNDER_SAT);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitUntilCycle(input int target);
    int n = 0;
    while (cyc < target && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Offer one sample and wait for it to be taken; keepValid leaves s_valid
  // high so the next call continues a back-to-back stream.
  task automatic applyStimulus(input int value, input bit keepValid);
    int start = xferCount;
    int n     = 0;
    sData  = W'(value);
    sValid = 1'b1;
    while (xferCount == start && n < 3 * PERIOD) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!keepValid) sValid = 1'b0;
  endtask

  initial begin
    $display("[TB] pwm_dac scoreboard bench start");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Midscale first period, then 256, extremes 0 / 1023, back-to-back run.
    waitUntilCycle(10);
    applyStimulus(256, 1'b0);
    applyStimulus(0, 1'b0);
    applyStimulus(1023, 1'b0);
    applyStimulus(100, 1'b1);
    applyStimulus(200, 1'b1);
    applyStimulus(300, 1'b0);

    // Three idle boundaries, then a transfer on the boundary edge itself.
    waitUntilCycle(10 * PERIOD - 1);
    applyStimulus(700, 1'b0);

    // Fill the holding register with 900, then reset at cnt = 400.
    waitUntilCycle(12 * PERIOD + 10);
    applyStimulus(900, 1'b0);
    waitUntilCycle(12 * PERIOD + 400);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;

    // Shortest-latency transfer at cnt = MAX-1, then idle periods.
    waitUntilCycle(PERIOD - 2);
    applyStimulus(64, 1'b0);
    waitUntilCycle(6 * PERIOD + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
